sifh_his_builder_param: RTL and testbench



---
 rtl/sifh_his_builder_param.sv | 240 ++++++++++++++++++++++++
 tb/tb_sifh_his_builder_param.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sifh_his_builder_param.sv
// sifh_his_builder_param
//   Two-pass SiFH histogram builder and peak detector. For every frame a coarse
//   pass bins the top NB bits of each ToF sample, a per-pixel zoom window is
//   derived from the coarse peak, and a fine pass bins ToF values inside that
//   window. One refined peak ToF per pixel is then streamed out.
// Ports
//   clk, res              clock, synchronous active-high reset
//   in_valid/in_ready     sample handshake, in_data = ToF sample (all-ones = no hit)
//   out_valid/out_ready   result handshake
//   out_pixel, out_tof    pixel index and refined peak ToF (all-ones = no peak)
//   out_peak, out_last    fine-pass peak count, marks pixel PIXELS-1
//   frame_done            one-cycle pulse when the out_last beat is accepted
module sifh_his_builder_param #(
  parameter int NP       = 12,
  parameter int NB       = 8,
  parameter int PIXELS   = 4,
  parameter int DATA_NUM = 2,
  parameter int ACQ_NUM  = 16,
  parameter int CNT_W    = 8,
  localparam int PW      = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NP-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_pixel,
  output logic [NP-1:0]    out_tof,
  output logic [CNT_W-1:0] out_peak,
  output logic             out_last,
  output logic             frame_done
);
  localparam int SW   = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int AW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int PN   = 1 << PW;
  localparam int BINS = 1 << NB;
  localparam int HW   = PW + NB;
  localparam int HN   = 1 << HW;
  localparam logic [SW-1:0] SAMP_LAST = SW'(DATA_NUM - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS - 1);
  localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_NUM - 1);
  localparam logic signed [NP+1:0] SB_S     = (NP+2)'(BINS / 2);
  localparam logic signed [NP+1:0] LO_MAX_S = (NP+2)'((1 << NP) - 1 - BINS);
  localparam logic [NP:0] WIN_SPAN = (NP+1)'(BINS - 1);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_COARSE = 3'd1;
  localparam logic [2:0] S_WIN    = 3'd2;
  localparam logic [2:0] S_FINE   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Window centred on the coarse bin, clamped so the window never covers the
  // no-hit code and never starts below zero.
  function automatic logic [NP-1:0] win_lo(input logic [NB-1:0] pb);
    logic signed [NP+1:0] ch;
    logic signed [NP+1:0] lo_s;
    ch   = {2'b00, pb, {(NP-NB){1'b0}}};
    lo_s = ch - SB_S;
    if (lo_s < 0) return '0;
    else if (lo_s > LO_MAX_S) return LO_MAX_S[NP-1:0];
    else return lo_s[NP-1:0];
  endfunction

  logic [2:0] state_q, state_d;
  logic [SW-1:0] samp_q;
  logic [PW-1:0] pix_q;
  logic [AW-1:0] acq_q;

  logic             vld_p1, vld_p2;
  logic [HW-1:0]    addr_p1, addr_p2;
  logic [CNT_W-1:0] cnt_p2, old_p1;

  logic [CNT_W-1:0]           hist_q [HN];
  logic [HN-1:0]              hv_q;
  logic [PN-1:0][CNT_W-1:0]   max_q;
  logic [PN-1:0][NB-1:0]      pbin_q;
  logic [PN-1:0][NP-1:0]      lo_q, lo_c;
  logic [PN-1:0]              chit_q, chit_c;

  logic             out_valid_q, out_last_q, frame_done_q;
  logic [PW-1:0]    out_pixel_q, ld_pix;
  logic [NP-1:0]    out_tof_q, ld_tof;
  logic [CNT_W-1:0] out_peak_q, ld_peak;
  logic             ld_last;

  logic          acc, last_c, hit_c, pipe_empty, win_go, drain_go, out_acc;
  logic [NB-1:0] bin_c;
  logic [NP:0]   off_c;
  logic [PW-1:0] pix_p2;
  logic [NB-1:0] bin_p2;

  assign in_ready   = (state_q == S_COARSE) || (state_q == S_FINE);
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_tof    = out_tof_q;
  assign out_peak   = out_peak_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

  assign acc        = in_valid && in_ready;
  assign last_c     = (samp_q == SAMP_LAST) && (pix_q == PIX_LAST) && (acq_q == ACQ_LAST);
  assign pipe_empty = !vld_p1 && !vld_p2;
  assign win_go     = (state_q == S_WIN) && pipe_empty;
  assign drain_go   = (state_q == S_DRAIN) && pipe_empty;
  assign out_acc    = out_valid_q && out_ready;
  assign pix_p2     = addr_p2[HW-1:NB];
  assign bin_p2     = addr_p2[NB-1:0];

  // Stage 0: hit detection and bin selection on the accepted sample.
  always_comb begin
    off_c = {1'b0, in_data} - {1'b0, lo_q[pix_q]};
    hit_c = 1'b0;
    bin_c = '0;
    if (state_q == S_COARSE) begin
      hit_c = (in_data != {NP{1'b1}});
      bin_c = in_data[NP-1:NP-NB];
    end else if (state_q == S_FINE) begin
      hit_c = (off_c <= WIN_SPAN);
      bin_c = off_c[NB-1:0];
    end
    hit_c = hit_c && acc;
  end

  // Stage 1: bin read; a bin still waiting in stage 2 is forwarded.
  always_comb begin
    if (vld_p2 && (addr_p2 == addr_p1)) old_p1 = cnt_p2;
    else if (hv_q[addr_p1])              old_p1 = hist_q[addr_p1];
    else                                 old_p1 = '0;
  end

  always_comb begin
    lo_c   = '0;
    chit_c = '0;
    for (int p = 0; p < PN; p++) begin
      chit_c[p] = (max_q[p] != '0);
      lo_c[p]   = chit_c[p] ? win_lo(pbin_q[p]) : '0;
    end
  end

  always_comb begin
    ld_pix  = (state_q == S_OUTPUT) ? out_pixel_q + PW'(1) : '0;
    ld_peak = max_q[ld_pix];
    ld_tof  = (chit_q[ld_pix] && (max_q[ld_pix] != '0)) ?
              lo_q[ld_pix] + NP'(pbin_q[ld_pix]) : {NP{1'b1}};
    ld_last = (ld_pix == PIX_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:  state_d = S_COARSE;
      S_COARSE: if (acc && last_c) state_d = S_WIN;
      S_WIN:    if (pipe_empty) state_d = S_FINE;
      S_FINE:   if (acc && last_c) state_d = S_DRAIN;
      S_DRAIN:  if (pipe_empty) state_d = S_OUTPUT;
      S_OUTPUT: if (out_acc && out_last_q) state_d = S_CLEAR;
      default:  state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_CLEAR;
      samp_q       <= '0;
      pix_q        <= '0;
      acq_q        <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_tof_q    <= '0;
      out_peak_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_p1       <= hit_c;
      vld_p2       <= vld_p1;
      frame_done_q <= 1'b0;
      if (state_q == S_CLEAR) begin
        samp_q <= '0;
        pix_q  <= '0;
        acq_q  <= '0;
      end else if (acc) begin
        if (samp_q == SAMP_LAST) begin
          samp_q <= '0;
          if (pix_q == PIX_LAST) begin
            pix_q <= '0;
            acq_q <= (acq_q == ACQ_LAST) ? '0 : acq_q + AW'(1);
          end else begin
            pix_q <= pix_q + PW'(1);
          end
        end else begin
          samp_q <= samp_q + SW'(1);
        end
      end
      if (drain_go || (state_q == S_OUTPUT && out_acc && !out_last_q)) begin
        out_valid_q <= 1'b1;
        out_pixel_q <= ld_pix;
        out_tof_q   <= ld_tof;
        out_peak_q  <= ld_peak;
        out_last_q  <= ld_last;
      end else if (state_q == S_OUTPUT && out_acc) begin
        out_valid_q  <= 1'b0;
        out_last_q   <= 1'b0;
        frame_done_q <= 1'b1;
      end
    end
  end

  // Stage 2: count write-back and strict-greater peak tracking.
  always_ff @(posedge clk) begin
    addr_p1 <= {pix_q, bin_c};
    addr_p2 <= addr_p1;
    cnt_p2  <= sat_inc(old_p1);
    if (vld_p2) hist_q[addr_p2] <= cnt_p2;
    if ((state_q == S_CLEAR) || win_go) begin
      hv_q   <= '0;
      max_q  <= '0;
      pbin_q <= '0;
    end else if (vld_p2) begin
      hv_q[addr_p2] <= 1'b1;
      if (cnt_p2 > max_q[pix_p2]) begin
        max_q[pix_p2]  <= cnt_p2;
        pbin_q[pix_p2] <= bin_p2;
      end
    end
    if (win_go) begin
      lo_q   <= lo_c;
      chit_q <= chit_c;
    end
  end
endmodule

// File: tb/tb_sifh_his_builder_param.sv
module tb_sifh_his_builder_param;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, out_valid, out_last, frame_done;
  logic [1:0]  out_pixel;
  logic [11:0] out_tof;
  logic [7:0]  out_peak;
  logic        in_ready4, out_valid4, out_last4, frame_done4;
  logic [1:0]  out_pixel4;
  logic [11:0] out_tof4;
  logic [3:0]  out_peak4;

  int errors = 0;
  int checks = 0;
  logic [11:0] fd [256];
  int exp_tof [2][4];
  int exp_pk  [2][4];

  sifh_his_builder_param dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_tof(out_tof),
    .out_peak(out_peak), .out_last(out_last), .frame_done(frame_done));

  sifh_his_builder_param #(.CNT_W(4)) dut4 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pixel(out_pixel4), .out_tof(out_tof4),
    .out_peak(out_peak4), .out_last(out_last4), .frame_done(frame_done4));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference: sample order i -> pixel (i/2)%4; each pass is 128 samples.
  task automatic run_model(input int k);
    int sat, d, p, b, v;
    int h [4][256];
    int mx [4];
    int pb [4];
    int lo [4];
    bit ch [4];
    bit hit;
    sat = (k == 0) ? 255 : 15;
    for (int q = 0; q < 4; q++) begin lo[q] = 0; ch[q] = 0; end
    for (int pass = 0; pass < 2; pass++) begin
      for (int q = 0; q < 4; q++) begin
        mx[q] = 0; pb[q] = 0;
        for (int j = 0; j < 256; j++) h[q][j] = 0;
      end
      for (int i = 0; i < 128; i++) begin
        d = int'(fd[pass*128 + i]);
        p = (i / 2) % 4;
        if (pass == 0) begin hit = (d != 4095); b = d / 16; end
        else begin hit = (d >= lo[p]) && (d <= lo[p] + 255); b = d - lo[p]; end
        if (hit) begin
          h[p][b] = (h[p][b] + 1 > sat) ? sat : h[p][b] + 1;
          if (h[p][b] > mx[p]) begin mx[p] = h[p][b]; pb[p] = b; end
        end
      end
      if (pass == 0) begin
        for (int q = 0; q < 4; q++) begin
          ch[q] = (mx[q] != 0);
          v = pb[q] * 16 - 128;
          if (v < 0) v = 0;
          if (v > 4095 - 256) v = 4095 - 256;
          lo[q] = ch[q] ? v : 0;
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      exp_tof[k][q] = (ch[q] && mx[q] != 0) ? lo[q] + pb[q] : 4095;
      exp_pk[k][q]  = mx[q];
    end
  endtask

  task automatic fill_const(input logic [11:0] v0, input logic [11:0] v1,
                            input logic [11:0] v2, input logic [11:0] v3);
    for (int i = 0; i < 256; i++) begin
      case ((i / 2) % 4)
        0: fd[i] = v0;
        1: fd[i] = v1;
        2: fd[i] = v2;
        default: fd[i] = v3;
      endcase
    end
  endtask

  task automatic fill_random();
    int base [4];
    int v;
    for (int q = 0; q < 4; q++) base[q] = $urandom_range(0, 4095);
    for (int i = 0; i < 256; i++) begin
      v = base[(i / 2) % 4] + $urandom_range(0, 24);
      if (v > 4095 || $urandom_range(0, 7) == 0) v = 4095;
      fd[i] = 12'(v);
    end
  endtask

  // Returns #1 after the edge that accepted the sample; in_valid stays high.
  task automatic send(input logic [11:0] d, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = 12'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_wait: in_ready actual=%b required=1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic collect(input int stall_pix);
    int n;
    logic [21:0] cap;
    for (int p = 0; p < 4; p++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (out_valid !== 1'b1 || out_valid4 !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_wait: pixel %0d actual=%b/%b required=1/1", p, out_valid, out_valid4);
      end
      if (p == stall_pix) begin
        cap = {out_pixel, out_tof, out_peak};
        repeat (5) begin
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || {out_pixel, out_tof, out_peak} !== cap) begin
            errors++;
            $display("FAIL stall_hold: actual=%b/%h required=1/%h", out_valid,
                     {out_pixel, out_tof, out_peak}, cap);
          end
        end
      end
      checks++;
      if (out_pixel !== 2'(p) || out_pixel4 !== 2'(p)) begin
        errors++; $display("FAIL out_pixel: actual=%0d/%0d required=%0d", out_pixel, out_pixel4, p);
      end
      checks++;
      if (out_tof !== 12'(exp_tof[0][p])) begin
        errors++; $display("FAIL out_tof p%0d: actual=%h required=%h", p, out_tof, 12'(exp_tof[0][p]));
      end
      checks++;
      if (out_peak !== 8'(exp_pk[0][p])) begin
        errors++; $display("FAIL out_peak p%0d: actual=%0d required=%0d", p, out_peak, exp_pk[0][p]);
      end
      checks++;
      if (out_tof4 !== 12'(exp_tof[1][p])) begin
        errors++; $display("FAIL out_tof_cnt4 p%0d: actual=%h required=%h", p, out_tof4, 12'(exp_tof[1][p]));
      end
      checks++;
      if (out_peak4 !== 4'(exp_pk[1][p])) begin
        errors++; $display("FAIL out_peak_cnt4 p%0d: actual=%0d required=%0d", p, out_peak4, exp_pk[1][p]);
      end
      checks++;
      if (out_last !== (p == 3) || out_last4 !== (p == 3)) begin
        errors++; $display("FAIL out_last p%0d: actual=%b/%b required=%b", p, out_last, out_last4, p == 3);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (frame_done !== (p == 3) || frame_done4 !== (p == 3)) begin
        errors++; $display("FAIL frame_done p%0d: actual=%b/%b required=%b", p, frame_done, frame_done4, p == 3);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL out_valid_after_last: actual=%b required=0", out_valid);
    end
  endtask

  task automatic do_frame(input bit gaps, input int stall_pix);
    int n;
    run_model(0);
    run_model(1);
    for (int i = 0; i < 256; i++) begin
      send(fd[i], gaps);
      if (i == 127) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL win_in_ready: actual=%b required=0", in_ready);
        end
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n <= 4) begin
      checks++;
      if (in_ready !== 1'b0 || in_ready4 !== 1'b0) begin
        errors++; $display("FAIL drain_in_ready: actual=%b/%b required=0", in_ready, in_ready4);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL out_latency: out_valid actual=%b required=1 within 4 cycles", out_valid);
    end
    collect(stall_pix);
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: actual rdy=%b vld=%b done=%b last=%b required all 0",
               in_ready, out_valid, frame_done, out_last);
    end
    checks++;
    if (out_pixel !== 2'd0 || out_tof !== 12'd0 || out_peak !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: actual pix=%0d tof=%h peak=%0d required 0", out_pixel, out_tof, out_peak);
    end
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin
      errors++; $display("FAIL reset_cnt4: actual vld=%b rdy=%b required 0", out_valid4, in_ready4);
    end
    res = 1'b0;
  endtask

  task automatic test_basic();
    fill_const(12'h3A5, 12'hFFF, 12'hFFF, 12'hFFF);
    do_frame(1'b0, -1);
  endtask

  task automatic test_clamp();
    fill_const(12'hFFF, 12'h005, 12'hFFE, 12'h7C3);
    do_frame(1'b0, -1);
  endtask

  task automatic test_saturate();
    fill_const(12'h100, 12'h100, 12'hFFF, 12'h0F0);
    do_frame(1'b0, -1);
  endtask

  task automatic test_tie();
    fill_const(12'h200, 12'hFFF, 12'hFFF, 12'hFFF);
    for (int i = 0; i < 256; i++)
      if ((i / 2) % 4 == 0 && (i % 128) >= 64) fd[i] = 12'h300;
    do_frame(1'b0, -1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    do_frame(1'b0, -1);
    do_frame(1'b1, -1);
  endtask

  task automatic test_stall();
    fill_random();
    do_frame(1'b1, 2);
  endtask

  task automatic test_reset_mid();
    fill_random();
    for (int i = 0; i < 148; i++) send(fd[i], 1'b0);
    in_valid = 1'b0;
    res = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid: actual vld=%b rdy=%b required 0/0", out_valid, in_ready);
    end
    res = 1'b0;
    do_frame(1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_saturate();
    test_tie();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
